// File: rtl/rv_instr_encoder.sv
// Purpose : encodes RV32I instruction descriptors (plus the LI pseudo-op) into
//           32-bit machine words and streams them sequentially into instruction memory.
// Latency : 1 cycle from accept to mem_we; LI with a non-zero upper part emits a 2nd word the cycle after.
// Backpr. : in_ready low while the ADDI half of an LI is pending or while the memory window is full.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   clear             synchronous restart of address/count/error/state, wins over everything else
//   in_valid/in_ready descriptor handshake; accept on in_valid && in_ready && !clear
//   kind, funct3, alt, rd, rs1, rs2, imm   instruction descriptor fields
//   mem_we/mem_addr/mem_wdata              registered write port toward instruction memory
//   word_count, full                        words written so far, and window-full flag
//   err                                     one-cycle pulse for a rejected descriptor
module rv_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 kind,
    input  logic [2:0]                 funct3,
    input  logic                       alt,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [31:0]                imm,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       full,
    output logic                       err
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;

    typedef enum logic [0:0] {RUN, LI_LO} state_t;
    state_t state, state_nxt;

    // ---------------- descriptor decode / encode ----------------
    logic signed [31:0] simm;
    logic               imm12_ok, bimm_ok, jimm_ok;
    logic               f3_alu_ok, f3_br_ok;
    logic [19:0]        li_hi;
    logic               legal, two_word;
    logic [31:0]        enc_word, li_lo_word;

    assign simm      = imm;
    assign imm12_ok  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign bimm_ok   = !imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
    assign jimm_ok   = !imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
    assign f3_alu_ok = (funct3 != 3'b001) && (funct3 != 3'b101);
    assign f3_br_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);

    // Rounded upper part: ADDI sign-extends its 12-bit immediate, so a set bit 11
    // in the low part must be compensated by one extra unit in the LUI value.
    assign li_hi      = 20'((imm + 32'h0000_0800) >> 12);
    assign li_lo_word = {imm[11:0], rd, 3'b000, rd, OP_ALUI};

    always_comb begin
        legal    = 1'b0;
        two_word = 1'b0;
        enc_word = '0;
        case (kind)
            4'd0: begin
                legal    = imm12_ok;
                enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            end
            4'd1: begin
                legal    = imm12_ok;
                enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            end
            4'd2: begin
                legal    = f3_br_ok && bimm_ok;
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            end
            4'd3: begin
                legal    = (imm[11:0] == 12'd0);
                enc_word = {imm[31:12], rd, OP_LUI};
            end
            4'd4: begin
                legal    = imm12_ok;
                enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            4'd5: begin
                legal    = jimm_ok;
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            4'd6: begin
                legal    = f3_alu_ok && imm12_ok;
                enc_word = {imm[11:0], rs1, funct3, rd, OP_ALUI};
            end
            4'd7: begin
                legal    = f3_alu_ok && (!alt || (funct3 == 3'b000));
                enc_word = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OP_ALUR};
            end
            4'd8: begin
                legal = 1'b1;
                if (li_hi != 20'd0) begin
                    two_word = 1'b1;
                    enc_word = {li_hi, rd, OP_LUI};
                end else begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, rd, OP_ALUI};
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // ---------------- handshake ----------------
    logic accept, reject, commit;

    assign full     = (word_count == CNT_FULL);
    assign in_ready = (state == RUN) && !full;
    assign accept   = in_valid && in_ready && !clear;
    // A two-word LI is refused outright rather than split across a full boundary.
    assign reject   = accept && (!legal || (two_word && (word_count == CNT_LAST)));
    assign commit   = accept && !reject;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (commit && two_word) state_nxt = LI_LO;
                LI_LO:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // ---------------- datapath ----------------
    logic [31:0] lo_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            lo_word    <= '0;
        end else if (clear) begin
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            // mem_addr names the word on the bus during its write cycle and
            // advances once that cycle is over.
            if (mem_we) mem_addr <= mem_addr + ADDR_W'(4);
            if (state == LI_LO) begin
                mem_we     <= 1'b1;
                mem_wdata  <= lo_word;
                word_count <= word_count + 1'b1;
            end else if (commit) begin
                mem_we     <= 1'b1;
                mem_wdata  <= enc_word;
                word_count <= word_count + 1'b1;
                if (two_word) lo_word <= li_lo_word;
            end else if (reject) begin
                err <= 1'b1;
            end
        end
    end

endmodule
